// File: rtl/sdram_pkg.sv
// Shared SDRAM command-bus definitions: command encodings, error codes, MRS field layout.
// Used by the init checker, the init sequencer and the read/write controller.
// Pure definitions, so no latency or flow control applies.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_BST  = 4'b0110;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_EARLY  = 3'd1;
    localparam logic [2:0] ERR_SEQ    = 3'd2;
    localparam logic [2:0] ERR_TIMING = 3'd3;
    localparam logic [2:0] ERR_MRSBAD = 3'd4;
    localparam logic [2:0] ERR_PALL   = 3'd5;

    // Mode register field positions on the address bus
    localparam int MRS_BL_LSB  = 0;
    localparam int MRS_BT_BIT  = 3;
    localparam int MRS_CL_LSB  = 4;
    localparam int MRS_OPM_LSB = 7;
    localparam int MRS_WS_BIT  = 9;
    localparam int PALL_BIT    = 10;

    // One bit per encoding: CAS latency 2/3; burst length 1/2/4/8/full-page
    localparam logic [7:0] CAS_LEGAL_MASK = 8'b0000_1100;
    localparam logic [7:0] BL_LEGAL_MASK  = 8'b1000_1111;

    // Only the commands that set a recovery gap need their own class
    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_PRE   = 2'd1,
        CLS_AREF  = 2'd2,
        CLS_MRS   = 2'd3
    } cmd_class_t;

    typedef enum logic [2:0] {
        ST_PWR      = 3'd0,
        ST_WAIT_PRE = 3'd1,
        ST_WAIT_AR  = 3'd2,
        ST_WAIT_MRS = 3'd3,
        ST_RUN      = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    // Deselect (CS_N high) behaves exactly like a NOP
    function automatic logic is_nop(input logic [3:0] cmd);
        return cmd[3] || (cmd == CMD_NOP);
    endfunction

    function automatic cmd_class_t classify(input logic [3:0] cmd);
        cmd_class_t cls;
        cls = CLS_OTHER;
        case (cmd)
            CMD_PRE:  cls = CLS_PRE;
            CMD_AREF: cls = CLS_AREF;
            CMD_MRS:  cls = CLS_MRS;
            CMD_ACT, CMD_RD, CMD_WR, CMD_BST, CMD_NOP: cls = CLS_OTHER;
            default:  cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    function automatic logic mrs_legal(input logic [1:0] ba, input logic [12:0] addr);
        logic [2:0] cl;
        logic [2:0] bl;
        cl = addr[MRS_CL_LSB +: 3];
        bl = addr[MRS_BL_LSB +: 3];
        return (ba == 2'b00) && CAS_LEGAL_MASK[cl] && BL_LEGAL_MASK[bl]
               && (addr[MRS_OPM_LSB +: 2] == 2'b00);
    endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Tracks NOP cycles since the last real command against the recovery gap that command needs.
// Registers update on the edge that samples the command; gap_ok is combinational from them.
// No backpressure: observes the bus every cycle. Ports: cmd_valid/cmd_class in, gap_ok out.
module sdram_gap_timer
    import sdram_pkg::*;
#(
    parameter int TRP_CLK  = 2,
    parameter int TRF_CLK  = 7,
    parameter int TMRD_CLK = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_class,
    output logic       gap_ok
);

    // The counter saturates at 15, so larger requirements are clamped to it
    localparam logic [3:0] REQ_PRE  = (TRP_CLK  > 15) ? 4'd15 : 4'(TRP_CLK);
    localparam logic [3:0] REQ_AREF = (TRF_CLK  > 15) ? 4'd15 : 4'(TRF_CLK);
    localparam logic [3:0] REQ_MRS  = (TMRD_CLK > 15) ? 4'd15 : 4'(TMRD_CLK);

    logic [3:0] gap;
    logic [3:0] req;
    logic [3:0] req_nxt;

    always_comb begin
        req_nxt = 4'd0;
        case (cmd_class)
            CLS_PRE:  req_nxt = REQ_PRE;
            CLS_AREF: req_nxt = REQ_AREF;
            CLS_MRS:  req_nxt = REQ_MRS;
            default:  req_nxt = 4'd0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap <= 4'd0;
            req <= 4'd0;
        end else if (cmd_valid) begin
            gap <= 4'd0;
            req <= req_nxt;
        end else if (gap != 4'd15) begin
            gap <= gap + 4'd1;
        end
    end

    assign gap_ok = (gap >= req);

endmodule

// File: rtl/sdram_init_checker.sv
// Passive checker of the SDRAM power-up init sequence: power wait, PRE, AREF, MRS, gap timing.
// Outputs are registered on the edge that samples cmd/ba/addr (visible one cycle later).
// No backpressure: purely observes the command bus; errors are reported, never stalled.
// Ports: cmd/ba/addr in; init_done, mode fields, aref_cnt, err/err_code/err_pulse out.
module sdram_init_checker
    import sdram_pkg::*;
#(
    parameter int T_POWER  = 10000,
    parameter int TRP_CLK  = 2,
    parameter int TRF_CLK  = 7,
    parameter int TMRD_CLK = 3,
    parameter int AREF_NUM = 1,
    parameter int CHK_PALL = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  cmd,
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    output logic        init_done,
    output logic        mode_valid,
    output logic [2:0]  burst_len,
    output logic        burst_type,
    output logic [2:0]  cas_lat,
    output logic        wr_single,
    output logic [3:0]  aref_cnt,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        err_pulse
);

    localparam int PW = (T_POWER < 2) ? 1 : $clog2(T_POWER + 1);
    localparam logic [PW-1:0] PWR_MAX = PW'(T_POWER);

    state_t      state;
    state_t      state_nxt;
    logic [PW-1:0] pwr_cnt;
    logic [PW-1:0] pwr_cnt_nxt;

    logic        cmd_valid;
    cmd_class_t  cls;
    logic        mrs_ok;
    logic        gap_ok;
    logic        aref_last;

    logic [2:0]  err_now;
    logic        mode_load;
    logic        mode_clear;
    logic        aref_inc;
    logic        done_set;

    assign cmd_valid   = !is_nop(cmd);
    assign cls         = classify(cmd);
    assign mrs_ok      = mrs_legal(ba, addr);
    assign pwr_cnt_nxt = (pwr_cnt < PWR_MAX) ? pwr_cnt + 1'b1 : pwr_cnt;
    assign aref_last   = (({1'b0, aref_cnt} + 5'd1) == 5'(AREF_NUM));

    sdram_gap_timer #(
        .TRP_CLK  (TRP_CLK),
        .TRF_CLK  (TRF_CLK),
        .TMRD_CLK (TMRD_CLK)
    ) u_gap (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_class (cls),
        .gap_ok    (gap_ok)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_PWR;
        else            state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            // Leave PWR on the edge the counter lands on T_POWER, so the
            // very next command is already judged against WAIT_PRE.
            ST_PWR: if (pwr_cnt_nxt == PWR_MAX) state_nxt = ST_WAIT_PRE;
            ST_WAIT_PRE: if (cmd_valid) state_nxt = (cls == CLS_PRE) ? ST_WAIT_AR : ST_ERR;
            ST_WAIT_AR: begin
                if (cmd_valid) begin
                    if (cls != CLS_AREF) state_nxt = ST_ERR;
                    else if (aref_last)  state_nxt = ST_WAIT_MRS;
                end
            end
            ST_WAIT_MRS: begin
                if (cmd_valid) state_nxt = (cls == CLS_MRS && mrs_ok) ? ST_RUN : ST_ERR;
            end
            default: state_nxt = state;
        endcase
    end

    // Error detection and register-update controls
    always_comb begin
        logic e_early, e_seq, e_timing, e_mrsbad, e_pall, mrs_dec;
        mrs_dec  = (state == ST_WAIT_MRS) || (state == ST_RUN);
        e_early  = cmd_valid && (state == ST_PWR) && (pwr_cnt < PWR_MAX);
        e_seq    = cmd_valid && (((state == ST_WAIT_PRE) && (cls != CLS_PRE))  ||
                                 ((state == ST_WAIT_AR)  && (cls != CLS_AREF)) ||
                                 ((state == ST_WAIT_MRS) && (cls != CLS_MRS)));
        e_timing = cmd_valid && !gap_ok;
        e_mrsbad = cmd_valid && mrs_dec && (cls == CLS_MRS) && !mrs_ok;
        e_pall   = (CHK_PALL != 0) && cmd_valid && (state == ST_WAIT_PRE) &&
                   (cls == CLS_PRE) && !addr[PALL_BIT];

        // Lowest code wins when several fire together
        if      (e_early)  err_now = ERR_EARLY;
        else if (e_seq)    err_now = ERR_SEQ;
        else if (e_timing) err_now = ERR_TIMING;
        else if (e_mrsbad) err_now = ERR_MRSBAD;
        else if (e_pall)   err_now = ERR_PALL;
        else               err_now = ERR_NONE;

        mode_load  = cmd_valid && mrs_dec && (cls == CLS_MRS) && mrs_ok;
        mode_clear = e_mrsbad;
        aref_inc   = cmd_valid && (state == ST_WAIT_AR) && (cls == CLS_AREF);
        done_set   = (state == ST_WAIT_MRS) && (state_nxt == ST_RUN);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwr_cnt    <= '0;
            init_done  <= 1'b0;
            mode_valid <= 1'b0;
            burst_len  <= 3'd0;
            burst_type <= 1'b0;
            cas_lat    <= 3'd0;
            wr_single  <= 1'b0;
            aref_cnt   <= 4'd0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_pulse  <= 1'b0;
        end else begin
            pwr_cnt   <= pwr_cnt_nxt;
            err_pulse <= (err_now != ERR_NONE);
            if ((err_now != ERR_NONE) && !err) begin
                err      <= 1'b1;
                err_code <= err_now;
            end
            if (done_set) init_done <= 1'b1;
            if (mode_load) begin
                mode_valid <= 1'b1;
                burst_len  <= addr[MRS_BL_LSB +: 3];
                burst_type <= addr[MRS_BT_BIT];
                cas_lat    <= addr[MRS_CL_LSB +: 3];
                wr_single  <= addr[MRS_WS_BIT];
            end else if (mode_clear) begin
                mode_valid <= 1'b0;
            end
            if (aref_inc && (aref_cnt != 4'd15)) aref_cnt <= aref_cnt + 4'd1;
        end
    end

endmodule
